// File: rtl/mem_pkg.sv
// Shared memory-system constants and types for the main memory model and the L1 cache controller.
package mem_pkg;

   localparam int DATA_WIDTH       = 256;
   localparam int MEM_DEPTH        = 512;
   localparam int ADDR_WIDTH       = 32;
   localparam int LINE_OFFSET_BITS = 5;
   localparam int INDEX_BITS       = 9;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Byte offset within a line and all bits above the index are dropped, so high addresses alias.
   function automatic logic [INDEX_BITS-1:0] line_index(input logic [ADDR_WIDTH-1:0] addr);
      return addr[LINE_OFFSET_BITS +: INDEX_BITS];
   endfunction

endpackage

// File: rtl/data_memory.sv
// Main memory model: one full cache line per request, acknowledged after a fixed latency.
module data_memory
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH = mem_pkg::DATA_WIDTH,
   parameter int MEM_DEPTH  = mem_pkg::MEM_DEPTH,
   parameter int LATENCY    = 10
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  enable_i,
   input  logic                  write_i,
   output logic                  ack_o,
   output logic [DATA_WIDTH-1:0] data_o
);

   localparam logic [7:0] LAST_COUNT = 8'(LATENCY - 1);

   logic [DATA_WIDTH-1:0] memory [0:MEM_DEPTH-1];

   state_t                state_reg;
   logic [7:0]            counter_reg;
   logic [INDEX_BITS-1:0] index_reg;
   logic [DATA_WIDTH-1:0] wdata_reg;
   logic                  write_reg;
   logic                  done;

   assign done = (state_reg == BUSY) && (counter_reg == LAST_COUNT);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg   <= IDLE;
         counter_reg <= '0;
         index_reg   <= '0;
         wdata_reg   <= '0;
         write_reg   <= 1'b0;
         ack_o       <= 1'b0;
         data_o      <= '0;
      end else begin
         ack_o <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (enable_i) begin
                  index_reg   <= line_index(addr_i);
                  wdata_reg   <= data_i;
                  write_reg   <= write_i;
                  counter_reg <= 8'd1;
                  state_reg   <= BUSY;
               end
            end
            BUSY: begin
               if (done) begin
                  // The ack cycle itself is IDLE, so a held enable_i starts the next request right away.
                  ack_o       <= 1'b1;
                  state_reg   <= IDLE;
                  counter_reg <= '0;
                  if (!write_reg) begin
                     data_o <= memory[index_reg];
                  end
               end else begin
                  counter_reg <= counter_reg + 8'd1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Storage has no reset; an aborted request never reaches done, so nothing commits.
   always_ff @(posedge clk_i) begin
      if (done && write_reg) begin
         memory[index_reg] <= wdata_reg;
      end
   end

endmodule

// File: tb/tb_data_memory.sv
// Randomized scoreboard bench for data_memory against an array-based reference model.
module tb_data_memory;
   import mem_pkg::*;

   localparam int LAT = 10;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [31:0]  req_addr = '0;
   logic [255:0] req_data = '0;
   logic         req_en = 1'b0;
   logic         req_wr = 1'b0;
   logic         ack;
   logic [255:0] dout;

   always #5 clk = ~clk;

   data_memory #(.LATENCY(LAT)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .addr_i  (req_addr),
      .data_i  (req_data),
      .enable_i(req_en),
      .write_i (req_wr),
      .ack_o   (ack),
      .data_o  (dout)
   );

   typedef struct {
      bit           is_write;
      int           idx;
      logic [255:0] wdata;
      logic [255:0] dout;
      int           ack_cycle;
   } exp_t;

   exp_t         sb[$];
   logic [255:0] model_mem [0:511];
   logic [255:0] model_dout = '0;
   int           cycle = 0;
   int           errors = 0;
   int           checks = 0;

   always @(posedge clk) cycle <= cycle + 1;

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every ack is matched against the oldest outstanding request.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst) continue;
         if (ack) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ack: got ack_o=1 at cycle %0d expected no ack", cycle);
            end else begin
               e = sb.pop_front();
               check("ack_cycle", 256'(cycle), 256'(e.ack_cycle));
               check(e.is_write ? "data_o_hold" : "read_data", dout, e.dout);
               if (e.is_write) check("write_commit", dut.memory[e.idx], e.wdata);
               $display("txn %s line %0d ack at cycle %0d data_o=%h", e.is_write ? "WR" : "RD",
                        e.idx, cycle, dout);
            end
         end else if (sb.size() > 0 && cycle > sb[0].ack_cycle) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_ack: got no ack by cycle %0d expected ack at cycle %0d", cycle, e.ack_cycle);
         end
      end
   end

   // Reference behaviour: reads see the model array at issue time, writes update it.
   task automatic push_expect(input bit w, input logic [31:0] addr, input logic [255:0] d);
      exp_t e;
      e.is_write  = w;
      e.idx       = int'(addr[13:5]);
      e.wdata     = d;
      e.ack_cycle = cycle + LAT - 1;
      if (w) model_mem[e.idx] = d;
      else   model_dout = model_mem[e.idx];
      e.dout = model_dout;
      sb.push_back(e);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < LAT + 20; i++) begin
         @(negedge clk);
         if (sb.size() == 0) return;
      end
      checks++;
      errors++;
      $display("FAIL timeout: got %0d outstanding requests expected 0", sb.size());
      sb.delete();
   endtask

   // hold = number of extra cycles the request inputs stay driven before being scrambled.
   task automatic issue(input bit w, input logic [31:0] addr, input logic [255:0] d, input int hold);
      @(negedge clk);
      req_en = 1'b1; req_wr = w; req_addr = addr; req_data = d;
      @(posedge clk);
      #1;
      push_expect(w, addr, d);
      repeat (hold) @(negedge clk);
      req_en = 1'b0; req_wr = 1'($urandom); req_addr = $urandom; req_data = rand256();
      wait_idle();
   endtask

   initial begin
      int c1;
      logic [255:0] d;
      logic [31:0]  a;

      // Backdoor preload during reset; reset must leave it intact.
      for (int i = 0; i < 512; i++) begin
         model_mem[i] = rand256();
         dut.memory[i] = model_mem[i];
      end
      model_mem[0] = 256'h5;
      dut.memory[0] = 256'h5;
      repeat (2) @(negedge clk);
      check("reset_ack", 256'(ack), 256'(0));
      check("reset_data_o", dout, '0);
      rst = 1'b0;
      @(negedge clk);
      check("preload_kept_0", dut.memory[0], 256'h5);
      check("preload_kept_3", dut.memory[3], model_mem[3]);

      issue(1'b0, 32'h0000_0000, '0, 0);                  // read + latency
      issue(1'b1, 32'h0000_0400, 256'hDEAD_BEEF, 0);      // write line 32
      check("mem32_direct", dut.memory[32], 256'hDEAD_BEEF);
      issue(1'b0, 32'h0000_041F, '0, 0);                  // read back with offset bits
      issue(1'b0, 32'h0000_4000, '0, 0);                  // alias to line 0

      // Inputs changed mid-flight on cycle 3 must be ignored.
      @(negedge clk);
      req_en = 1'b1; req_wr = 1'b1; req_addr = 32'h20; req_data = 256'hAA;
      @(posedge clk);
      #1;
      push_expect(1'b1, 32'h20, 256'hAA);
      repeat (2) @(negedge clk);
      req_addr = 32'h40; req_data = 256'hBB; req_en = 1'b0;
      wait_idle();
      check("busy_change_line2", dut.memory[2], model_mem[2]);

      // Back-to-back reads with enable held through the ack cycle.
      @(negedge clk);
      req_en = 1'b1; req_wr = 1'b0; req_addr = 32'h20;
      @(posedge clk);
      #1;
      push_expect(1'b0, 32'h20, '0);
      c1 = cycle;
      req_addr = 32'h40;
      while (cycle < c1 + LAT) begin
         @(posedge clk);
         #1;
      end
      push_expect(1'b0, 32'h40, '0);
      req_en = 1'b0;
      wait_idle();

      // Reset mid-write: nothing commits, outputs clear asynchronously.
      d = rand256();
      @(negedge clk);
      req_en = 1'b1; req_wr = 1'b1; req_addr = 32'h60; req_data = d;
      @(posedge clk);
      #1;
      req_en = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async_reset_ack", 256'(ack), 256'(0));
      check("async_reset_data_o", dout, '0);
      model_dout = '0;
      repeat (3) @(negedge clk);
      check("aborted_write_line3", dut.memory[3], model_mem[3]);
      check("reset_keeps_line32", dut.memory[32], 256'hDEAD_BEEF);
      rst = 1'b0;
      repeat (LAT + 2) @(negedge clk);
      check("aborted_write_after", dut.memory[3], model_mem[3]);
      issue(1'b0, 32'h0000_0060, '0, 0);

      // Randomized traffic, biased to a few lines so writes get read back.
      for (int n = 0; n < 40; n++) begin
         a = $urandom;
         if ($urandom_range(0, 1) == 1) a[13:5] = 9'($urandom_range(0, 7));
         issue(1'($urandom_range(0, 1)), a, rand256(), int'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
